// File: rtl/race_start_sequencer.sv
// race_start_sequencer
//   Sequences one drag-race run. It drives the three amber start lights and
//   then green, detects a false start, enables the speed datapath, counts the
//   elapsed time in ticks and keeps the best completed time.
//
// Parameters
//   TICK_DIV     clock cycles per time tick (>= 2)
//   STAGE_TICKS  ticks each amber light stays lit (>= 1)
//   TIME_W       width of the time values; they saturate at all ones
//
// Ports
//   Clock_i        system clock
//   Resetn_i       asynchronous active-low reset
//   NewGame_i      single-cycle start/restart request
//   Accelerate_i   player throttle (level)
//   Finish_i       run completed (pulse from the race SM)
//   Crash_i        run aborted (pulse from the race SM)
//   Lights_o       [3:1] amber 3..1, [0] green
//   RaceEnable_o   high only while racing
//   FalseStart_o   high after a false start
//   Elapsed_o      run time in ticks
//   BestTime_o     best completed run time
//   BestValid_o    BestTime_o holds a real result
//   NewBest_o      one-cycle pulse when BestTime_o is updated
//   State_o        encoded state: IDLE=0 AMBER=1 RUN=2 DONE=3 FOUL=4 CRASHED=5
//   Reaction_o     (only with RACE_REACTION_EN) ticks from green to first throttle
//
// Optional feature macro: RACE_REACTION_EN
module race_start_sequencer #(
  parameter int TICK_DIV    = 500000,
  parameter int STAGE_TICKS = 50,
  parameter int TIME_W      = 14
) (
  input  logic              Clock_i,
  input  logic              Resetn_i,
  input  logic              NewGame_i,
  input  logic              Accelerate_i,
  input  logic              Finish_i,
  input  logic              Crash_i,
  output logic [3:0]        Lights_o,
  output logic              RaceEnable_o,
  output logic              FalseStart_o,
  output logic [TIME_W-1:0] Elapsed_o,
  output logic [TIME_W-1:0] BestTime_o,
  output logic              BestValid_o,
  output logic              NewBest_o,
`ifdef RACE_REACTION_EN
  output logic [TIME_W-1:0] Reaction_o,
`endif
  output logic [2:0]        State_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STAGE_TICKS + 1);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]     STAGE_LAST = SW'(STAGE_TICKS - 1);
  localparam logic [TIME_W-1:0] TIME_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AMBER   = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_FOUL    = 3'd4,
    S_CRASHED = 3'd5
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     presc_q;
  logic [SW-1:0]     stage_tmr_q;
  logic [1:0]        stage_q;
  logic [3:0]        lights_q;
  logic              race_en_q;
  logic              foul_q;
  logic [TIME_W-1:0] elapsed_q;
  logic [TIME_W-1:0] best_q;
  logic              best_valid_q;
  logic              new_best_q;
`ifdef RACE_REACTION_EN
  logic [TIME_W-1:0] reaction_q;
  logic              reacted_q;
`endif

  logic tick;
  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      stage_tmr_q  <= '0;
      stage_q      <= '0;
      lights_q     <= '0;
      race_en_q    <= 1'b0;
      foul_q       <= 1'b0;
      elapsed_q    <= '0;
      best_q       <= '1;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
`ifdef RACE_REACTION_EN
      reaction_q   <= '0;
      reacted_q    <= 1'b0;
`endif
    end else begin
      new_best_q <= 1'b0;
      // Free-running prescaler; every state change below re-zeroes it so a
      // state always starts on a full tick period.
      presc_q    <= tick ? '0 : presc_q + 1'b1;

      if (NewGame_i) begin
        // Start or restart from any state; best time survives.
        state_q     <= S_AMBER;
        presc_q     <= '0;
        stage_tmr_q <= '0;
        stage_q     <= 2'd3;
        lights_q    <= 4'b1000;
        race_en_q   <= 1'b0;
        foul_q      <= 1'b0;
        elapsed_q   <= '0;
`ifdef RACE_REACTION_EN
        reaction_q  <= '0;
        reacted_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_AMBER: begin
            if (Accelerate_i) begin
              // False start beats a stage expiry in the same cycle.
              state_q   <= S_FOUL;
              presc_q   <= '0;
              lights_q  <= '0;
              foul_q    <= 1'b1;
              elapsed_q <= '0;
            end else if (tick) begin
              if (stage_tmr_q == STAGE_LAST) begin
                stage_tmr_q <= '0;
                if (stage_q == 2'd1) begin
                  state_q   <= S_RUN;
                  presc_q   <= '0;
                  stage_q   <= '0;
                  lights_q  <= 4'b0001;
                  race_en_q <= 1'b1;
                end else begin
                  stage_q  <= stage_q - 2'd1;
                  lights_q <= lights_q >> 1;
                end
              end else begin
                stage_tmr_q <= stage_tmr_q + 1'b1;
              end
            end
          end

          S_RUN: begin
            if (Crash_i) begin
              state_q   <= S_CRASHED;
              presc_q   <= '0;
              lights_q  <= '0;
              race_en_q <= 1'b0;
            end else if (Finish_i) begin
              // The tick coinciding with Finish is dropped, so elapsed_q is
              // already the final time and the best update can happen here,
              // landing together with the first DONE cycle.
              state_q   <= S_DONE;
              presc_q   <= '0;
              lights_q  <= '0;
              race_en_q <= 1'b0;
              if (!best_valid_q || (elapsed_q < best_q)) begin
                best_q       <= elapsed_q;
                best_valid_q <= 1'b1;
                new_best_q   <= 1'b1;
              end
            end else begin
              if (tick && (elapsed_q != TIME_MAX))
                elapsed_q <= elapsed_q + 1'b1;
`ifdef RACE_REACTION_EN
              if (!reacted_q) begin
                if (Accelerate_i)
                  reacted_q <= 1'b1;
                else if (tick && (reaction_q != TIME_MAX))
                  reaction_q <= reaction_q + 1'b1;
              end
`endif
            end
          end

          default: ; // IDLE, DONE, FOUL, CRASHED wait for NewGame
        endcase
      end
    end
  end

  assign State_o      = state_q;
  assign Lights_o     = lights_q;
  assign RaceEnable_o = race_en_q;
  assign FalseStart_o = foul_q;
  assign Elapsed_o    = elapsed_q;
  assign BestTime_o   = best_q;
  assign BestValid_o  = best_valid_q;
  assign NewBest_o    = new_best_q;
`ifdef RACE_REACTION_EN
  assign Reaction_o   = reaction_q;
`endif

endmodule

// File: tb/tb_race_start_sequencer.sv
// Bench for race_start_sequencer with TICK_DIV=4, STAGE_TICKS=2, TIME_W=4.
// A cycles-in-state model predicts every output each cycle; directed runs
// pin the model with literal expectations, then random stimulus follows.
module tb_race_start_sequencer;
  localparam int TD = 4;
  localparam int ST = 2;
  localparam int TW = 4;
  localparam int AMBER_CYC = 3 * TD * ST;
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ng = 1'b0, acc = 1'b0, fin = 1'b0, crash = 1'b0;
  logic [3:0]    lights;
  logic          re, fs, bv, nb;
  logic [TW-1:0] el, best;
  logic [2:0]    st;
`ifdef RACE_REACTION_EN
  logic [TW-1:0] reaction;
`endif

  race_start_sequencer #(.TICK_DIV(TD), .STAGE_TICKS(ST), .TIME_W(TW)) dut (
    .Clock_i(clk), .Resetn_i(rst_n), .NewGame_i(ng), .Accelerate_i(acc),
    .Finish_i(fin), .Crash_i(crash), .Lights_o(lights), .RaceEnable_o(re),
    .FalseStart_o(fs), .Elapsed_o(el), .BestTime_o(best), .BestValid_o(bv),
    .NewBest_o(nb),
`ifdef RACE_REACTION_EN
    .Reaction_o(reaction),
`endif
    .State_o(st)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: state code, cycles spent in the current state, and the time values.
  int m_st, m_cyc, m_el, m_best, m_bv, m_nb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_cyc <= 0; m_el <= 0; m_best <= TMAX; m_bv <= 0; m_nb <= 0;
    end else begin
      m_nb <= 0;
      if (ng) begin
        m_st <= 1; m_cyc <= 0; m_el <= 0;
      end else begin
        case (m_st)
          1: if (acc) begin m_st <= 4; m_cyc <= 0; m_el <= 0; end
             else if (m_cyc + 1 == AMBER_CYC) begin m_st <= 2; m_cyc <= 0; end
             else m_cyc <= m_cyc + 1;
          2: if (crash) begin m_st <= 5; m_cyc <= 0; end
             else if (fin) begin
               m_st <= 3; m_cyc <= 0;
               if (m_bv == 0 || m_el < m_best) begin
                 m_best <= m_el; m_bv <= 1; m_nb <= 1;
               end
             end else begin
               if ((m_cyc + 1) % TD == 0 && m_el < TMAX) m_el <= m_el + 1;
               m_cyc <= m_cyc + 1;
             end
          default: m_cyc <= m_cyc + 1;
        endcase
      end
    end
  end

  function automatic int m_lights();
    if (m_st == 1) return 8 >> (m_cyc / (TD * ST));
    if (m_st == 2) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("state", st, m_st);
      chk("lights", lights, m_lights());
      chk("race_en", re, m_st == 2);
      chk("false_start", fs, m_st == 4);
      chk("elapsed", el, m_el);
      chk("best", best, m_best);
      chk("best_valid", bv, m_bv);
      chk("new_best", nb, m_nb);
    end
  end

  task automatic new_game();
    @(negedge clk) ng = 1'b1;
    @(negedge clk) ng = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (st == s) return;
      @(negedge clk);
    end
    chk("wait_state_timeout", st, s);
  endtask

  task automatic wait_elapsed(input int v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (el == v) return;
      @(negedge clk);
    end
    chk("wait_elapsed_timeout", el, v);
  endtask

  task automatic wait_lights(input int v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (lights == v) return;
      @(negedge clk);
    end
    chk("wait_lights_timeout", lights, v);
  endtask

  // Full run: start, wait for green, let `ticks` elapse, hold `extra`
  // cycles, then pulse Finish/Crash. Returns in the first cycle after it.
  task automatic race(input int ticks, input int extra, input bit f, input bit c);
    new_game();
    wait_state(2, AMBER_CYC + 4);
    wait_elapsed(ticks, ticks * TD + 8);
    repeat (extra) @(negedge clk);
    fin = f; crash = c;
    @(negedge clk) fin = 1'b0; crash = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_lights"}, lights, 0);
    chk({tag, "_race_en"}, re, 0);
    chk({tag, "_false_start"}, fs, 0);
    chk({tag, "_elapsed"}, el, 0);
    chk({tag, "_best"}, best, TMAX);
    chk({tag, "_best_valid"}, bv, 0);
    chk({tag, "_new_best"}, nb, 0);
  endtask

  initial begin
    #23 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    cmp_en = 1'b1;

    // Light sequence: 8 cycles per amber, green in cycle 25 after NewGame.
    new_game();
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1 || c == 8)   chk("seq_amber3", lights, 4'b1000);
      if (c == 9 || c == 16)  chk("seq_amber2", lights, 4'b0100);
      if (c == 17 || c == 24) chk("seq_amber1", lights, 4'b0010);
      if (c == 24) chk("seq_no_enable_yet", re, 0);
      if (c == 25) begin
        chk("seq_green", lights, 4'b0001);
        chk("seq_enable", re, 1);
      end
    end

    // Saturation: 20 ticks at TIME_W=4 holds at 15; Finish records 15.
    wait_elapsed(15, 15 * TD + 8);
    repeat (5 * TD) @(negedge clk);
    chk("sat_hold", el, 15);
    fin = 1'b1;
    @(negedge clk) fin = 1'b0;
    chk("sat_best", best, 15);
    chk("sat_state", st, 3);

    race(12, 0, 1, 0);
    chk("run12_elapsed", el, 12);
    chk("run12_best", best, 12);
    chk("run12_newbest", nb, 1);
    chk("run12_valid", bv, 1);
    chk("model_best12", m_best, 12);
    @(negedge clk) chk("run12_newbest_drop", nb, 0);

    race(15, 0, 1, 0);
    chk("run15_best", best, 12);
    chk("run15_no_newbest", nb, 0);

    race(12, 0, 1, 0);
    chk("tie_best", best, 12);
    chk("tie_no_newbest", nb, 0);

    race(9, 0, 1, 0);
    chk("run9_best", best, 9);
    chk("run9_newbest", nb, 1);
    chk("model_best9", m_best, 9);

    race(5, 0, 1, 1);
    chk("crash_state", st, 5);
    chk("crash_best", best, 9);
    chk("crash_no_newbest", nb, 0);

    // False start while amber 2 is lit.
    new_game();
    wait_lights(4'b0100, AMBER_CYC);
    acc = 1'b1;
    @(negedge clk) acc = 1'b0;
    chk("foul_state", st, 4);
    chk("foul_flag", fs, 1);
    chk("foul_lights", lights, 0);
    chk("foul_race_en", re, 0);
    chk("foul_best", best, 9);

    // Asynchronous reset in the middle of a run.
    new_game();
    wait_state(2, AMBER_CYC + 4);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk) chk_reset_vals("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", st, 0);
    chk("post_rst_valid", bv, 0);

    // Random play checked every cycle by the model.
    repeat (4000) begin
      @(negedge clk);
      ng    = ($urandom_range(0, 119) == 0);
      acc   = ($urandom_range(0, 49) == 0);
      fin   = ($urandom_range(0, 24) == 0);
      crash = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk) begin ng = 0; acc = 0; fin = 0; crash = 0; end
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
